// File: rtl/z80_mem_arbiter_pkg.sv
// Shared types and default widths for the Z80 memory arbiter slice.
package z80_bus_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 8;

    // Arbiter ownership of the single memory port.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/z80_mem_arbiter_if.sv
// CPU, DMA and memory-port signals of the arbiter; master = arbiter side.
interface z80_mem_arbiter_if #(
    parameter int unsigned AW = z80_bus_pkg::AW_DEF,
    parameter int unsigned DW = z80_bus_pkg::DW_DEF
);
    logic          cpu_mreq_n;
    logic          cpu_rd_n;
    logic          cpu_wr_n;
    logic          cpu_rfsh_n;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_di;
    logic          cpu_wait_n;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_dout,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_ack, mem_rdata,
        output cpu_di, cpu_wait_n, dma_ack, dma_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_dout,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_ack, mem_rdata,
        input  cpu_di, cpu_wait_n, dma_ack, dma_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/z80_cyc_tracker.sv
// Tracks the current CPU memory cycle: strobe decode, completion flag and wait stretch.
module z80_cyc_tracker (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_mreq_n,
    input  logic cpu_rd_n,
    input  logic cpu_wr_n,
    input  logic cpu_rfsh_n,
    input  logic cpu_acc,
    input  logic cpu_ack,
    output logic cpu_strobe,
    output logic cpu_pend,
    output logic cpu_wait_n
);

    logic done_q;

    // Refresh and I/O cycles never reach memory.
    assign cpu_strobe = ~cpu_mreq_n & cpu_rfsh_n & (~cpu_rd_n | ~cpu_wr_n);
    assign cpu_pend   = cpu_strobe & ~done_q & ~cpu_acc;
    assign cpu_wait_n = ~(cpu_strobe & ~done_q);

    // Completion holds until the CPU drops its strobe; an aborted cycle never completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else if (!cpu_strobe) begin
            done_q <= 1'b0;
        end else if (cpu_ack) begin
            done_q <= 1'b1;
        end
    end

endmodule

// File: rtl/z80_mem_arbiter.sv
// Shares one memory port between the TV80 bus and a DMA requester, with a DMA starvation guard.
module z80_mem_arbiter
    import z80_bus_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    z80_mem_arbiter_if.master  bus
);

    localparam int unsigned CW = 4;

    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_di_q, cpu_di_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic [CW-1:0] starve_q, starve_d;

    logic cpu_strobe;
    logic cpu_pend;
    logic dma_win;
    logic cpu_grant;
    logic dma_grant;

    z80_cyc_tracker u_trk (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_mreq_n (bus.cpu_mreq_n),
        .cpu_rd_n   (bus.cpu_rd_n),
        .cpu_wr_n   (bus.cpu_wr_n),
        .cpu_rfsh_n (bus.cpu_rfsh_n),
        .cpu_acc    (state_q == ARB_CPU),
        .cpu_ack    (bus.mem_ack && (state_q == ARB_CPU)),
        .cpu_strobe (cpu_strobe),
        .cpu_pend   (cpu_pend),
        .cpu_wait_n (bus.cpu_wait_n)
    );

    // DMA takes idle gaps, or the slot outright once the CPU has won STARVE_MAX times.
    assign dma_win = bus.dma_req & ~dma_ack_q &
                     (~cpu_pend | (starve_q == CW'(STARVE_MAX)));

    // Next-state, grant latching, completion capture and starvation count.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_di_d    = cpu_di_q;
        dma_ack_d   = 1'b0;
        dma_rdata_d = dma_rdata_q;
        starve_d    = starve_q;
        cpu_grant   = 1'b0;
        dma_grant   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (dma_win) begin
                    state_d     = ARB_DMA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dma_we;
                    mem_addr_d  = bus.dma_addr;
                    mem_wdata_d = bus.dma_wdata;
                    dma_grant   = 1'b1;
                end else if (cpu_pend) begin
                    state_d     = ARB_CPU;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~bus.cpu_wr_n;
                    mem_addr_d  = bus.cpu_a;
                    mem_wdata_d = bus.cpu_dout;
                    cpu_grant   = 1'b1;
                end
            end
            ARB_CPU: begin
                if (bus.mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q && cpu_strobe) begin
                        cpu_di_d = bus.mem_rdata;
                    end
                end
            end
            ARB_DMA: begin
                if (bus.mem_ack) begin
                    state_d     = ARB_IDLE;
                    mem_req_d   = 1'b0;
                    dma_ack_d   = 1'b1;
                    dma_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (!bus.dma_req || dma_grant) begin
            starve_d = '0;
        end else if (cpu_grant && (starve_q != CW'(STARVE_MAX))) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_di_q    <= '0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_di_q    <= cpu_di_d;
            dma_ack_q   <= dma_ack_d;
            dma_rdata_q <= dma_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_di    = cpu_di_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_rdata = dma_rdata_q;

endmodule
